sync_upcounter_mod: RTL
=======================

// Module: sync_upcounter_mod
// PURPOSE
// - Synchronous modulo-N up counter built structurally from T flip-flops.
// - Counts in the up direction, wraps at MODULUS-1, and supports synchronous clear and parallel load.
// - Terminal-count output lets several stages be cascaded into wider or decade chains.
// - Serves as the up-counting counterpart to the team's synchronous down counter, e.g. for timers and BCD digit chains.
// PARAMETERS
// - WIDTH    4   counter width in bits; valid range 2..16.
// - MODULUS  10  count sequence is 0..MODULUS-1; valid range 2..2**WIDTH.
// PORTS
// - clk  input   1      rising-edge clock; the only clock.
// - rst  input   1      asynchronous, active-low reset (0 = reset).
// - en   input   1      count enable.
// - clr  input   1      synchronous clear.
// - ld   input   1      synchronous parallel load.
// - d    input   WIDTH  load value.
// - q    output  WIDTH  count value.
// - qb   output  WIDTH  bitwise complement of q.
// - tc   output  1      terminal count, combinational; cascade carry.
// BEHAVIOUR
// - Reset: rst=0 forces q=0 and qb={WIDTH{1'b1}} immediately, with no clock edge needed.
//   - tc=0 while rst=0 because q=0 and MODULUS>=2.
//   - Reset asserted mid-count aborts the count at once.
//   - The first rising edge with rst=1 operates normally.
// - All other updates happen on the rising clk edge, with 1-cycle latency.
// - Priority per edge, highest first:
//   - clr=1: next q=0.
//   - ld=1: next q=d. d is loaded unchanged, even if d>=MODULUS.
//   - en=1 and q>=MODULUS-1: next q=0 (wrap; this also recovers out-of-range values).
//   - en=1 and q<MODULUS-1: next q=q+1.
//   - otherwise q holds.
// - Every update is realised as T inputs to the flip-flops, never as direct D writes:
//   - clear: t=q.
//   - load: t=q^d.
//   - wrap: t=q.
//   - increment: t[0]=1, t[i]=&q[i-1:0] (AND-chain of true outputs).
//   - hold: t=0.
// - tc = en & (q==MODULUS-1) & ~clr & ~ld, evaluated combinationally with no register.
// - Cascading: tc of stage k drives en of stage k+1. The upper stage therefore advances on the same edge the lower stage wraps.
// - Simultaneous events:
//   - clr and ld together: clear wins.
//   - ld and en together: load wins; no increment that cycle, and tc=0.
// - MODULUS=2**WIDTH gives natural binary wrap: 2**WIDTH-1 -> 0.
// - qb always equals ~q, including during reset.
// STRUCTURE
// - Shared include counter_defs.vh holds:
//   - default WIDTH and MODULUS.
//   - the `MOD_BCD` constant (10).
//   - a parameter range-check macro for elaboration-time errors.
// - Sub-module tff_arn: T flip-flop with ports (q, qb, clk, rst, t).
//   - async active-low reset to q=0.
//   - toggles on the rising edge when t=1.
// - The top level instantiates WIDTH tff_arn through a generate loop, plus the T-input next-state logic and the tc compare.
// TESTING
// - Reset: WIDTH=4, MODULUS=10.
//   - rst=0 mid-count at q=7 -> q=0, qb=4'hF before the next edge.
//   - Release, then en=1 -> q=1 after the first edge.
// - Count and wrap: en=1 for 12 edges from 0 -> q runs 1..9, 0, 1, 2. tc=1 only while q=9.
// - Load and priority:
//   - ld=1, d=6 -> q=6.
//   - clr=1 with ld=1, d=3 -> q=0.
//   - ld=1, en=1 at q=9 -> q=d and tc=0.
// - Out-of-range load: ld=1, d=4'hC, then en=1 -> q=0 on the next edge. en=0 holds q=C.
// - Binary mode: MODULUS=16 -> q counts 14, 15, 0. tc=1 at 15.
// - Cascade: two instances with MODULUS=10 and tc0 driving en1.
//   - after 100 enabled edges -> {q1,q0}=00.
//   - at 99 the upper tc=1.

Source files
------------

// File: rtl/sync_upcounter_mod_pkg.sv
// Shared types for the synchronous up counter: per-edge operation select and
// the priority function that picks it (clear > load > wrap/increment > hold).
// Latency: none (types and pure functions only). Backpressure: not applicable.
`include "counter_defs.vh"

package sync_upcounter_mod_pkg;

   localparam int DEF_WIDTH   = `CNT_DEF_WIDTH;
   localparam int DEF_MODULUS = `CNT_DEF_MODULUS;
   localparam int MOD_BCD     = `MOD_BCD;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_CLR  = 3'd1,
      OP_LD   = 3'd2,
      OP_WRAP = 3'd3,
      OP_INC  = 3'd4
   } cnt_op_t;

   // at_top is "q >= MODULUS-1", so out-of-range loaded values also wrap.
   function automatic cnt_op_t sel_op(input logic clr, input logic ld,
                                      input logic en, input logic at_top);
      cnt_op_t op;
      op = OP_HOLD;
      if (clr)         op = OP_CLR;
      else if (ld)     op = OP_LD;
      else if (en)     op = at_top ? OP_WRAP : OP_INC;
      return op;
   endfunction

endpackage

// File: rtl/counter_defs.vh
// Shared counter definitions: default geometry, the BCD modulus constant and
// an elaboration-time parameter range check.
// Safe to include from several files of the same compilation unit.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH

`define CNT_DEF_WIDTH   4
`define CNT_DEF_MODULUS 10
`define MOD_BCD         10

// Expands to a generate block that stops elaboration when val is
// outside lo..hi.
`define CNT_RANGE_CHECK(val, lo, hi) \
   if (((val) < (lo)) || ((val) > (hi))) begin \
      $error("counter parameter out of range: %0d not in %0d..%0d", (val), (lo), (hi)); \
   end

`endif

// File: rtl/sync_upcounter_mod_tff.sv
// T flip-flop with asynchronous active-low reset to q=0; toggles on rising clk when t=1.
// Latency: 1 cycle from t to q. Backpressure: none.
// Ports: q/qb state and complement, clk, rst (0 = reset), t toggle enable.
module tff_arn (
   output logic q,
   output logic qb,
   input  logic clk,
   input  logic rst,
   input  logic t
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)   q <= 1'b0;
      else if (t) q <= ~q;
   end

   assign qb = ~q;

endmodule

// File: rtl/sync_upcounter_mod.sv
// Modulo-MODULUS up counter built from T flip-flops, with sync clear/load and cascade tc.
// Latency: 1 cycle for q; tc is combinational. Backpressure: none (en gates counting).
// Ports: clk, rst (async, 0 = reset), en, clr, ld, d (load value) -> q, qb = ~q, tc.
`include "counter_defs.vh"

module sync_upcounter_mod
   import sync_upcounter_mod_pkg::*;
#(
   parameter int WIDTH   = `CNT_DEF_WIDTH,
   parameter int MODULUS = `CNT_DEF_MODULUS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc
);

   `CNT_RANGE_CHECK(WIDTH, 2, 16)
   `CNT_RANGE_CHECK(MODULUS, 2, (1 << WIDTH))

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

   cnt_op_t          op;
   logic [WIDTH-1:0] t;
   logic             carry;

   assign op = sel_op(clr, ld, en, (q >= TOP));

   // Every update is a toggle mask: bits that must change get t=1.
   always_comb begin
      t     = '0;
      carry = 1'b1;
      unique case (op)
         OP_CLR,
         OP_WRAP: t = q;            // toggle every set bit -> all zero
         OP_LD:   t = q ^ d;        // toggle exactly the differing bits
         OP_INC: begin
            // bit i toggles when all lower bits are 1 (ripple AND chain)
            for (int i = 0; i < WIDTH; i++) begin
               t[i]  = carry;
               carry = carry & q[i];
            end
         end
         default: t = '0;
      endcase
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      tff_arn u_tff (
         .q   (q[g]),
         .qb  (qb[g]),
         .clk (clk),
         .rst (rst),
         .t   (t[g])
      );
   end

   // Carry to the next stage: asserted only on a real wrap edge.
   assign tc = en & (q == TOP) & ~clr & ~ld;

endmodule
